pipe_arb_ctrl: RTL

- Shares the 3-stage arithmetic pipeline F = (a + b + (c - d)) * d between NREQ requesters.
- Round-robin arbitration; at most one issue per cycle.
- Registers the winner's operands and drives them into the pipeline.
- Tracks valid/ID alongside the datapath and returns F tagged with the originating requester.
- Sits between the requester blocks and the free-running (unstallable, unreset) pipeline datapath.

---
 rtl/pipe_arb_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pipe_arb_ctrl.sv
// Round-robin issue controller for the shared 3-stage F = (a + b + (c - d)) * d datapath.
// Define PIPE_ARB_STATS_EN to add the issue_cnt / drop_cnt statistics ports.
module pipe_arb_ctrl #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 3
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] op_a,
  input  logic [4*NREQ-1:0] op_b,
  input  logic [4*NREQ-1:0] op_c,
  input  logic [4*NREQ-1:0] op_d,
  input  logic              issue_en,
  output logic [NREQ-1:0]   gnt,
  output logic [3:0]        pipe_a,
  output logic [3:0]        pipe_b,
  output logic [3:0]        pipe_c,
  output logic [3:0]        pipe_d,
  input  logic [11:0]       pipe_f,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [11:0]       rsp_data,
  output logic              busy
`ifdef PIPE_ARB_STATS_EN
  ,
  output logic [15:0]       issue_cnt,
  output logic [7:0]        drop_cnt
`endif
);

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0]     pipe_a_q, pipe_a_d;
  logic [3:0]     pipe_b_q, pipe_b_d;
  logic [3:0]     pipe_c_q, pipe_c_d;
  logic [3:0]     pipe_d_q, pipe_d_d;

  // Tag stage 0 rides with the operand register; the datapath result lines up
  // with stage LAT-1, and the response register is the final tag stage.
  logic [LAT-1:0]          tag_v_q, tag_v_d;
  logic [LAT-1:0][IDW-1:0] tag_id_q, tag_id_d;

  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [11:0]    rsp_data_q, rsp_data_d;

  logic           found;
  logic           any_req;
  logic           hi_req;
  logic [IDW-1:0] low_idx;
  logic [IDW-1:0] hi_idx;
  logic [IDW-1:0] win;

  // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    any_req = 1'b0;
    hi_req  = 1'b0;
    low_idx = '0;
    hi_idx  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_req = 1'b1;
        low_idx = IDW'(i);
        if (IDW'(i) >= rr_ptr_q) begin
          hi_req = 1'b1;
          hi_idx = IDW'(i);
        end
      end
    end
    found = issue_en && any_req;
    win   = hi_req ? hi_idx : low_idx;
  end

  always_comb begin
    gnt      = '0;
    pipe_a_d = pipe_a_q;
    pipe_b_d = pipe_b_q;
    pipe_c_d = pipe_c_q;
    pipe_d_d = pipe_d_q;
    rr_ptr_d = rr_ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (found && (win == IDW'(i))) begin
        gnt[i]   = 1'b1;
        pipe_a_d = op_a[4*i +: 4];
        pipe_b_d = op_b[4*i +: 4];
        pipe_c_d = op_c[4*i +: 4];
        pipe_d_d = op_d[4*i +: 4];
      end
    end
    if (found) begin
      rr_ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
    end
  end

  always_comb begin
    tag_v_d     = '0;
    tag_id_d    = '0;
    tag_v_d[0]  = found;
    tag_id_d[0] = win;
    for (int i = 1; i < LAT; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end
    rsp_valid_d = tag_v_q[LAT-1];
    rsp_id_d    = tag_id_q[LAT-1];
    rsp_data_d  = pipe_f;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      pipe_a_q    <= '0;
      pipe_b_q    <= '0;
      pipe_c_q    <= '0;
      pipe_d_q    <= '0;
      tag_v_q     <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      pipe_a_q    <= pipe_a_d;
      pipe_b_q    <= pipe_b_d;
      pipe_c_q    <= pipe_c_d;
      pipe_d_q    <= pipe_d_d;
      tag_v_q     <= tag_v_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign pipe_a    = pipe_a_q;
  assign pipe_b    = pipe_b_q;
  assign pipe_c    = pipe_c_q;
  assign pipe_d    = pipe_d_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (|tag_v_q) || rsp_valid_q;

`ifdef PIPE_ARB_STATS_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  // issue_cnt wraps freely; drop_cnt saturates so a long stall stays visible.
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (found) begin
      issue_cnt_d = issue_cnt_q + 16'd1;
    end
    if ((req != '0) && !found && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`endif

endmodule
